// File: rtl/uart_pkg.sv
// uart_pkg: UART register map, status bits, response codes and loader states
package uart_pkg;
  localparam logic [7:0] CTRL_OFS   = 8'h00;
  localparam logic [7:0] BAUD_OFS   = 8'h04;
  localparam logic [7:0] STATUS_OFS = 8'h08;
  localparam logic [7:0] TX_OFS     = 8'h0C;
  localparam logic [7:0] RX_OFS     = 8'h10;
  localparam int STATUS_TX_FULL = 1;
  localparam int RX_VALID       = 8;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  typedef enum logic [2:0] {IDLE, HDR, DATA, FLUSH, CSUM, RESP_CHK, RESP_WR} state_t;
endpackage

// File: rtl/uart_loader_packer.sv
// uart_loader_packer: gathers payload bytes into a 32-bit word with per-lane byte enables
module uart_loader_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [1:0]  lane,
  input  logic [7:0]  data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        full
);
  assign full = load && lane == 2'd3;
  always_ff @(posedge clk)
    if (rst || clear) begin
      wdata <= '0;
      be <= '0;
    end else if (load) begin
      wdata[8*lane +: 8] <= data;
      be[lane] <= 1'b1;
    end
endmodule

// File: rtl/uart_loader.sv
// uart_loader: parses framed load commands from the UART RX FIFO into memory writes and answers ACK/NAK
module uart_loader
  import uart_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [7:0]  uart_address,
  input  logic [31:0] uart_read_data,
  output logic        uart_re,
  output logic        uart_we,
  output logic [31:0] uart_write_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);
  state_t state;
  logic [31:0] cur_addr, tcnt;
  logic [15:0] remaining;
  logic [2:0]  hcnt;
  logic [7:0]  csum, code, b;
  logic fetch, counting, timeout, clear, word_done, unused;
  assign b = uart_read_data[7:0];
  assign unused = ^uart_read_data[31:9];
  assign fetch = state inside {IDLE, HDR, DATA, CSUM};
  assign counting = state inside {HDR, DATA, CSUM};
  assign uart_re = !rst && en && fetch && uart_read_data[RX_VALID];
  assign timeout = counting && !uart_re && tcnt == 32'(TIMEOUT_CYCLES - 1);
  assign clear = !en || timeout || (state == FLUSH && mem_ready);
  assign busy = state != IDLE;
  uart_loader_packer packer (
    .clk(clk), .rst(rst), .clear(clear), .load(uart_re && state == DATA),
    .lane(cur_addr[1:0]), .data(b), .wdata(mem_wdata), .be(mem_be), .full(word_done)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      uart_address <= RX_OFS;
      uart_we <= 1'b0;
      uart_write_data <= '0;
      mem_addr <= '0;
      mem_we <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      cur_addr <= '0;
      remaining <= '0;
      hcnt <= '0;
      csum <= '0;
      code <= '0;
      tcnt <= '0;
    end else if (!en) begin
      state <= IDLE;
      uart_address <= RX_OFS;
      uart_we <= 1'b0;
      uart_write_data <= '0;
      mem_addr <= '0;
      mem_we <= 1'b0;
      done <= 1'b0;
      tcnt <= '0;
    end else if (timeout) begin
      state <= IDLE;
      err <= 1'b1;
      tcnt <= '0;
    end else begin
      // idle time is measured only while waiting for frame bytes
      tcnt <= uart_re ? '0 : counting ? tcnt + 32'd1 : tcnt;
      case (state)
        IDLE: if (uart_re && b == SYNC_BYTE) begin
          state <= HDR;
          err <= 1'b0;
          csum <= '0;
          hcnt <= '0;
        end
        HDR: if (uart_re) begin
          csum <= csum ^ b;
          hcnt <= hcnt + 3'd1;
          if (hcnt < 3'd4) cur_addr <= {b, cur_addr[31:8]};
          else remaining <= {b, remaining[15:8]};
          if (hcnt == 3'd5) state <= ({b, remaining[15:8]} == 16'd0) ? CSUM : DATA;
        end
        DATA: if (uart_re) begin
          csum <= csum ^ b;
          cur_addr <= cur_addr + 32'd1;
          remaining <= remaining - 16'd1;
          if (word_done || remaining == 16'd1) begin
            state <= FLUSH;
            mem_we <= 1'b1;
            mem_addr <= {cur_addr[31:2], 2'b00};
          end
        end
        FLUSH: if (mem_ready) begin
          mem_we <= 1'b0;
          state <= (remaining != 16'd0) ? DATA : CSUM;
        end
        CSUM: if (uart_re) begin
          code <= (b == csum) ? ACK : NAK;
          state <= RESP_CHK;
          uart_address <= STATUS_OFS;
        end
        RESP_CHK: if (!uart_read_data[STATUS_TX_FULL]) begin
          state <= RESP_WR;
          uart_address <= TX_OFS;
          uart_we <= 1'b1;
          uart_write_data <= {24'd0, code};
          done <= 1'b1;
          err <= err || code == NAK;
        end
        RESP_WR: begin
          state <= IDLE;
          uart_address <= RX_OFS;
          uart_we <= 1'b0;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed and random frames against a byte-level memory image and response model
module tb_uart_loader;
  import uart_pkg::*;
  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] be; } wr_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, mem_ready = 1'b0;
  logic [31:0] uart_read_data = '0;
  logic [7:0] uart_address;
  logic uart_re, uart_we, mem_we, busy, done, err;
  logic [31:0] uart_write_data, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  always #5 clk = ~clk;
  uart_loader #(.TIMEOUT_CYCLES(100), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .en(en), .uart_address(uart_address), .uart_read_data(uart_read_data),
    .uart_re(uart_re), .uart_we(uart_we), .uart_write_data(uart_write_data), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we), .mem_ready(mem_ready),
    .busy(busy), .done(done), .err(err)
  );
  logic [7:0] rx_q[$], tx_log[$];
  wr_t wr_log[$];
  wr_t prev;
  logic [7:0] dmem[logic [31:0]], rmem[logic [31:0]];
  logic rx_on = 1'b1, tx_full = 1'b0, rand_ready = 1'b1, prev_hold = 1'b0;
  int stall_left = 0, stall_seen = 0, done_cnt = 0, proto_bad = 0, pops = 0, errors = 0, checks = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock: drive inputs at the falling edge, observe what the next rising edge will see
  task automatic step();
    uart_read_data = (uart_address == RX_OFS) ? {23'd0, rx_on && rx_q.size() != 0, rx_q.size() != 0 ? rx_q[0] : 8'h00}
                   : (uart_address == STATUS_OFS) ? {30'd0, tx_full, 1'b0} : 32'd0;
    if (mem_we === 1'b1 && stall_left > 0) begin
      mem_ready = 1'b0;
      stall_left--;
      stall_seen++;
    end else mem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    if (uart_re === 1'b1 && (uart_we === 1'b1 || mem_we === 1'b1)) proto_bad++;
    if (prev_hold && (mem_we !== 1'b1 || mem_addr !== prev.a || mem_wdata !== prev.d || mem_be !== prev.be)) proto_bad++;
    prev_hold = en && !rst && mem_we === 1'b1 && !mem_ready;
    prev = '{mem_addr, mem_wdata, mem_be};
    if (uart_re === 1'b1) begin
      void'(rx_q.pop_front());
      pops++;
    end
    if (uart_we === 1'b1 && uart_address == TX_OFS) tx_log.push_back(uart_write_data[7:0]);
    if (done === 1'b1) done_cnt++;
    if (mem_we === 1'b1 && mem_ready) begin
      if (mem_addr[1:0] != 2'd0) proto_bad++;
      wr_log.push_back('{mem_addr, mem_wdata, mem_be});
      for (int l = 0; l < 4; l++) if (mem_be[l]) dmem[{mem_addr[31:2], 2'(l)}] = mem_wdata[8*l +: 8];
    end
    @(negedge clk);
  endtask

  task automatic push_frame(logic [31:0] a, logic [7:0] p[$], bit bad);
    logic [47:0] h = {16'(p.size()), a};
    logic [7:0] x = 8'h00;
    rx_q.push_back(8'hA5);
    for (int i = 0; i < 6; i++) begin
      rx_q.push_back(h[8*i +: 8]);
      x ^= h[8*i +: 8];
    end
    foreach (p[i]) begin
      rx_q.push_back(p[i]);
      x ^= p[i];
    end
    rx_q.push_back(x ^ {7'd0, bad});
  endtask

  task automatic chk_mem(string tag);
    int mm = (dmem.num() != rmem.num()) ? 1 : 0;
    foreach (rmem[k]) if (!dmem.exists(k) || dmem[k] !== rmem[k]) mm++;
    chk({tag, " mem"}, 64'(mm), 0);
  endtask

  task automatic run_frame(string tag, logic [31:0] a, logic [7:0] p[$], bit bad);
    int d0 = done_cnt, n = 0;
    int words = (p.size() == 0) ? 0 : (int'(a[1:0]) + p.size() + 3) / 4;
    wr_log.delete();
    tx_log.delete();
    push_frame(a, p, bad);
    foreach (p[i]) rmem[a + 32'(i)] = p[i];
    while (done_cnt == d0 && n < 5000) begin
      step();
      n++;
    end
    chk({tag, " done"}, 64'(done_cnt - d0), 1);
    chk({tag, " tx_n"}, 64'(tx_log.size()), 1);
    chk({tag, " code"}, 64'(tx_log.size() != 0 ? tx_log[0] : 8'h00), bad ? 64'h15 : 64'h06);
    chk({tag, " err"}, 64'(err), 64'(bad));
    chk({tag, " writes"}, 64'(wr_log.size()), 64'(words));
    chk({tag, " proto"}, 64'(proto_bad), 0);
    chk_mem(tag);
  endtask

  task automatic chk_idle(string tag);
    chk({tag, " ctl"}, {uart_address, uart_re, uart_we, mem_we, busy, done, mem_be}, {8'h10, 5'b0, 4'h0});
    chk({tag, " data"}, {uart_write_data, mem_wdata}, 64'd0);
    chk({tag, " maddr"}, 64'(mem_addr), 0);
  endtask

  initial begin
    logic [7:0] p[$];
    int n, d0, p0;
    @(negedge clk);
    repeat (3) step();
    chk_idle("reset");
    chk("reset err", 64'(err), 0);
    rst = 1'b0;
    p.delete();
    for (int i = 0; i < 8; i++) p.push_back(8'(8'h11 + i));
    run_frame("basic", 32'h1000, p, 1'b0);
    chk("basic w0", {wr_log[0].a, wr_log[0].d}, 64'h00001000_14131211);
    chk("basic w1", {wr_log[1].a, wr_log[1].d}, 64'h00001004_18171615);
    chk("basic be", {wr_log[0].be, wr_log[1].be}, 8'hFF);
    p.delete();
    p.push_back(8'hAA); p.push_back(8'hBB); p.push_back(8'hCC);
    run_frame("unal", 32'h1003, p, 1'b0);
    chk("unal w0", {wr_log[0].a, wr_log[0].d[31:24], wr_log[0].be}, {32'h1000, 8'hAA, 4'h8});
    chk("unal w1", {wr_log[1].a, wr_log[1].d[15:0], wr_log[1].be}, {32'h1004, 16'hCCBB, 4'h3});
    p.delete();
    for (int i = 0; i < 5; i++) p.push_back(8'($urandom));
    run_frame("nak", 32'h5001, p, 1'b1);
    run_frame("after_nak", 32'h5100, p, 1'b0);
    // stalled memory and full TX FIFO
    rand_ready = 1'b0; stall_left = 5; stall_seen = 0; tx_full = 1'b1;
    p.delete();
    for (int i = 0; i < 4; i++) p.push_back(8'($urandom));
    wr_log.delete(); tx_log.delete(); d0 = done_cnt;
    push_frame(32'h4000, p, 1'b0);
    foreach (p[i]) rmem[32'h4000 + 32'(i)] = p[i];
    n = 0;
    while (rx_q.size() != 0 && n < 200) begin step(); n++; end
    repeat (10) step();
    chk("stall tx_held", {32'(tx_log.size()), 32'(done_cnt - d0)}, 64'd0);
    chk("stall busy", 64'(busy), 1);
    chk("stall seen", 64'(stall_seen), 5);
    chk("stall writes", 64'(wr_log.size()), 1);
    tx_full = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 50) begin step(); n++; end
    repeat (3) step();
    chk("stall tx", {32'(tx_log.size()), 24'd0, tx_log.size() != 0 ? tx_log[0] : 8'h00}, {32'd1, 32'h06});
    chk("stall proto", 64'(proto_bad), 0);
    chk_mem("stall");
    rand_ready = 1'b1;
    // timeout after three payload bytes, junk ahead of SYNC
    wr_log.delete(); tx_log.delete();
    rx_q.push_back(8'h00); rx_q.push_back(8'h37);
    p.delete();
    for (int i = 0; i < 8; i++) p.push_back(8'($urandom));
    push_frame(32'h2000, p, 1'b0);
    repeat (6) void'(rx_q.pop_back());
    n = 0;
    while (rx_q.size() != 0 && n < 100) begin step(); n++; end
    chk("to busy", 64'(busy), 1);
    repeat (99) step();
    chk("to early", 64'(err), 0);
    step();
    chk("to err", 64'(err), 1);
    chk("to idle", {busy, mem_be}, 5'd0);
    chk("to silent", {32'(wr_log.size()), 32'(tx_log.size())}, 64'd0);
    // reset mid-DATA
    p0 = pops;
    push_frame(32'h3000, p, 1'b0);
    n = 0;
    while (pops - p0 < 9 && n < 100) begin step(); n++; end
    chk("rst partial", {busy, mem_be}, 5'b1_0011);
    rst = 1'b1;
    rx_q.delete();
    step();
    rst = 1'b0;
    chk_idle("rst");
    chk("rst err", 64'(err), 0);
    run_frame("post_rst", 32'h3000, p, 1'b0);
    // enable dropped mid-DATA
    p0 = pops;
    push_frame(32'h3800, p, 1'b0);
    n = 0;
    while (pops - p0 < 9 && n < 100) begin step(); n++; end
    en = 1'b0;
    step();
    chk_idle("en");
    rx_q.delete();
    en = 1'b1;
    run_frame("post_en", 32'h3800, p, 1'b0);
    for (int k = 0; k < 12; k++) begin
      logic [31:0] a = (k == 0) ? 32'hFFFF_FFFE : $urandom;
      int len = (k == 1) ? 0 : (k == 0) ? 6 : $urandom_range(0, 20);
      p.delete();
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      run_frame($sformatf("rnd%0d", k), a, p, $urandom_range(0, 3) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
